// File: rtl/game_clk_divider_if.sv
// Control/status bundle for game_clk_divider.
// The tick source drives enable/sync_clr/load/load_div through the master
// modport; the divider consumes them and returns clk_out/tick_out through
// the slave modport. CHANNELS and CNT_W must match the divider instance.
interface game_clk_divider_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 26
);
  logic [CHANNELS-1:0]       enable;
  logic                      sync_clr;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*CNT_W-1:0] load_div;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       tick_out;

  modport master (
    output enable,
    output sync_clr,
    output load,
    output load_div,
    input  clk_out,
    input  tick_out
  );

  modport slave (
    input  enable,
    input  sync_clr,
    input  load,
    input  load_div,
    output clk_out,
    output tick_out
  );
endinterface

// File: rtl/game_clk_divider.sv
// Multi-channel clock/tick generator for frame-rate, animation and debounce
// timing. Each channel divides clk_in by its own divisor D (0 behaves as 1)
// and produces a 50%-duty divided clock (period 2D) and a one-cycle tick at
// each terminal count. sync_clr phase-aligns every channel at once.
//
// Build option: define GAME_CLK_DIVIDER_LOAD_EN to allow run-time divisor
// reloads through load/load_div. Without it the divisor is fixed at
// DEFAULT_DIV, load/load_div are ignored, and the port list is identical.
module game_clk_divider #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 20000000
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  game_clk_divider_if.slave    bus
);

  localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(DEFAULT_DIV);

  logic [CHANNELS-1:0] clk_vec;
  logic [CHANNELS-1:0] tick_vec;

  assign bus.clk_out  = clk_vec;
  assign bus.tick_out = tick_vec;

`ifndef GAME_CLK_DIVIDER_LOAD_EN
  // Load inputs exist only to keep the port list stable; fold them away.
  logic unused_load;
  assign unused_load = ^{bus.load, bus.load_div};
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] d_last;
    logic             load_i;
    logic             terminal;
    logic             clk_q;
    logic             tick_q;

`ifdef GAME_CLK_DIVIDER_LOAD_EN
    assign load_i = bus.load[i];

    // Divisor register: reloaded on load, even while sync_clr is active.
    // NOTE: every sequential register here takes the async reset and is
    // written only with non-blocking assignments, so all channels update
    // from the same pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        div_reg <= DIV_RESET;
      end else if (load_i) begin
        div_reg <= bus.load_div[i*CNT_W +: CNT_W];
      end
    end
`else
    assign load_i  = 1'b0;
    assign div_reg = DIV_RESET;
`endif

    // Terminal-count detect; a zero divisor counts as divide-by-one.
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
      d_last   = '0;
      terminal = 1'b0;
      if (div_reg != '0) begin
        d_last = div_reg - 1'b1;
      end
      if (bus.enable[i] && (counter == d_last)) begin
        terminal = 1'b1;
      end
    end

    // Counter, divided clock and tick in priority order:
    // sync_clr, load, terminal count, enabled count, hold.
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        counter <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else if (bus.sync_clr) begin
        counter <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else if (load_i) begin
        // Clearing on load keeps the counter below any new, smaller D.
        counter <= '0;
        tick_q  <= 1'b0;
      end else if (terminal) begin
        counter <= '0;
        clk_q   <= ~clk_q;
        tick_q  <= 1'b1;
      end else if (bus.enable[i]) begin
        counter <= counter + 1'b1;
        tick_q  <= 1'b0;
      end else begin
        tick_q  <= 1'b0;
      end
    end

    assign clk_vec[i]  = clk_q;
    assign tick_vec[i] = tick_q;
  end

endmodule

// File: doc/game_clk_divider.md
# game_clk_divider

Parametrised multi-channel clock/tick generator that replaces the single fixed divide-by-20,000,000 toggle divider. Each channel divides the system clock by its own divisor, which can be reloaded at run time. Each channel produces a 50%-duty divided clock and a one-cycle tick strobe. The block feeds the game's frame-rate, animation and input-debounce timing logic. All channels run in the single system clock domain.

## Interface
Parameters:
- CHANNELS, 2, number of independent divider channels (1..8)
- CNT_W, 26, counter and divisor width in bits
- DEFAULT_DIV, 20000000, divisor loaded at reset; must satisfy 1 <= DEFAULT_DIV < 2^CNT_W

Ports:
- clk_in  input  1  system clock; all logic on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  CHANNELS  per-channel count enable
- sync_clr  input  1  synchronous phase-align of all channels
- load  input  CHANNELS  per-channel divisor load strobe
- load_div  input  CHANNELS*CNT_W  new divisors; channel i uses bits [i*CNT_W +: CNT_W]
- clk_out  output  CHANNELS  divided clock per channel, registered
- tick_out  output  CHANNELS  one-cycle strobe per channel at terminal count, registered

## Operation
- Per-channel state: counter[i] (CNT_W bits), div_reg[i] (CNT_W bits), clk_out[i], tick_out[i].
- The effective divisor is D = div_reg[i]. A value of 0 is treated as D = 1.
- Terminal condition: enable[i] is high and counter[i] == D-1.
- Per-channel priority on each rising edge, highest first:
  1. sync_clr: counter[i] <= 0, clk_out[i] <= 0, tick_out[i] <= 0. div_reg[i] is still updated if load[i] is high.
  2. load[i]: div_reg[i] <= load_div slice, counter[i] <= 0, tick_out[i] <= 0. clk_out[i] holds its value.
  3. Terminal: counter[i] <= 0, clk_out[i] <= ~clk_out[i], tick_out[i] <= 1.
  4. enable[i] high: counter[i] <= counter[i]+1, tick_out[i] <= 0.
  5. enable[i] low: counter[i] and clk_out[i] hold, tick_out[i] <= 0.
- If a divisor is lowered while counter[i] >= D-1 without a load, the counter cannot overshoot. This is guaranteed because every load also clears the counter.
- Channels are fully independent except for the shared sync_clr.

## Timing
- Reset (rst_n low, asynchronous): all counters 0, all clk_out 0, all tick_out 0, all div_reg = DEFAULT_DIV.
- Release of rst_n is sampled at the next rising edge. The team's top-level reset synchroniser guarantees deassertion timing.
- With enable held high from reset:
  - the first tick_out pulse is high during the cycle after the D-th rising edge;
  - tick_out then repeats every D cycles;
  - clk_out toggles on the same edges, giving period 2D and 50% duty.
- D = 1: tick_out is high continuously; clk_out toggles every cycle (period 2 clk_in).
- Load latency: a new divisor governs counting from the edge after the load. The first tick comes D_new enabled cycles after the load edge.
- sync_clr latency: one cycle. After sync_clr, all channels with equal D and enable high tick on the same cycle.
- tick_out is never high for two consecutive cycles unless D = 1.

## Configuration
- Macro: GAME_CLK_DIVIDER_LOAD_EN.
- Defined: runtime loading operates as described under Operation.
- Undefined:
  - load and load_div are ignored and div_reg stays constant at DEFAULT_DIV;
  - load[i] has no effect on counter[i];
  - the port list is unchanged, so the instantiation is identical in both builds.

## Test plan
Bench settings: CHANNELS=2, CNT_W=8, DEFAULT_DIV=4 unless stated.
- Reset then enable=2'b11 -> tick_out[0] high for 1 cycle every 4 cycles, first pulse after the 4th edge; clk_out[0] period 8 cycles; all outputs 0 during rst_n low.
- Load channel 1 with 3 mid-count (counter=2), macro defined -> counter1 cleared, clk_out[1] holds; next tick after 3 cycles, then every 3 cycles. Macro undefined -> channel 1 keeps period 4, unaffected.
- enable[0] low for 5 cycles at counter=1 -> counter and clk_out[0] frozen, no ticks; resumes and ticks 3 cycles after re-enable.
- Load divisors 0 and 1 -> both channels show tick_out stuck high and clk_out toggling every cycle.
- Channels on D=4 and D=4 with phases offset by 2, then pulse sync_clr -> both clk_out drop to 0 and subsequent ticks coincide.
- Assert rst_n low asynchronously mid-count with div_reg loaded to 7 -> outputs 0 immediately without a clock edge; after release, period returns to DEFAULT_DIV (4).
